fwd_hazard_ctrl: RTL

//  Produces the forwarding selects for the EXE stage (ALU_src1, ALU_src2, Store_Value_sel) and the load-use stall.

---
 rtl/fwd_hazard_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller. It sits in ID and tracks
// the destinations of the instructions now in EXE and MEM.
module fwd_hazard_ctrl #(
   parameter int REG_ADDR_LEN = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    freeze,
   input  logic                    flush,
   input  logic                    id_valid,
   input  logic [REG_ADDR_LEN-1:0] id_src1,
   input  logic [REG_ADDR_LEN-1:0] id_src2,
   input  logic                    id_use_src1,
   input  logic                    id_use_src2,
   input  logic                    id_is_store,
   input  logic [REG_ADDR_LEN-1:0] id_dest,
   input  logic                    id_wb_en,
   input  logic                    id_mem_read,
   output logic                    stall,
   output logic [1:0]              ALU_src1,
   output logic [1:0]              ALU_src2,
   output logic [1:0]              Store_Value_sel,
   output logic                    exe_valid
);

   typedef logic [REG_ADDR_LEN-1:0] reg_t;

   typedef struct packed {
      logic v;
      reg_t dest;
      logic wb_en;
      logic mem_read;
   } e_slot_t;

   typedef struct packed {
      logic v;
      reg_t dest;
      logic wb_en;
   } m_slot_t;

   localparam logic [1:0] SEL_RF  = 2'd0;
   localparam logic [1:0] SEL_MEM = 2'd1;
   localparam logic [1:0] SEL_WB  = 2'd2;

   e_slot_t    e_q;
   m_slot_t    m_q;
   logic [1:0] src1_q, src2_q, store_q;

   logic       hit_e1, hit_e2, hit_m1, hit_m2;
   logic       issue;
   logic [1:0] src1_d, src2_d, store_d;

   // Register 0 is hardwired zero, so it never matches a producer.
   function automatic logic hit(input logic v, input logic wb_en,
                                input reg_t dest, input reg_t r);
      return (r != '0) && v && wb_en && (dest == r);
   endfunction

   // The EXE slot holds the youngest value, so it wins over MEM.
   function automatic logic [1:0] pick(input logic he, input logic hm);
      if (he)      return SEL_MEM;
      else if (hm) return SEL_WB;
      else         return SEL_RF;
   endfunction

   always_comb begin
      // NOTE: every signal driven here gets a default first so no latch is inferred.
      hit_e1  = 1'b0;
      hit_e2  = 1'b0;
      hit_m1  = 1'b0;
      hit_m2  = 1'b0;
      src1_d  = SEL_RF;
      src2_d  = SEL_RF;
      store_d = SEL_RF;
      stall   = 1'b0;
      issue   = 1'b0;

      hit_e1 = hit(e_q.v, e_q.wb_en, e_q.dest, id_src1);
      hit_e2 = hit(e_q.v, e_q.wb_en, e_q.dest, id_src2);
      hit_m1 = hit(m_q.v, m_q.wb_en, m_q.dest, id_src1);
      hit_m2 = hit(m_q.v, m_q.wb_en, m_q.dest, id_src2);

      if (id_use_src1) src1_d  = pick(hit_e1, hit_m1);
      if (id_use_src2) src2_d  = pick(hit_e2, hit_m2);
      if (id_is_store) store_d = pick(hit_e2, hit_m2);

      // A load in EXE cannot forward yet; a flush discards the consumer instead.
      stall = id_valid & ~flush & e_q.v & e_q.mem_read &
              ((hit_e1 & id_use_src1) | (hit_e2 & (id_use_src2 | id_is_store)));
      issue = id_valid & ~flush & ~stall;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         e_q     <= '0;
         m_q     <= '0;
         src1_q  <= SEL_RF;
         src2_q  <= SEL_RF;
         store_q <= SEL_RF;
      end else if (!freeze) begin
         m_q <= '{v: e_q.v, dest: e_q.dest, wb_en: e_q.wb_en};
         if (issue) begin
            e_q     <= '{v: 1'b1, dest: id_dest, wb_en: id_wb_en, mem_read: id_mem_read};
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            store_q <= store_d;
         end else begin
            e_q     <= '0;
            src1_q  <= SEL_RF;
            src2_q  <= SEL_RF;
            store_q <= SEL_RF;
         end
      end
   end

   assign ALU_src1        = src1_q;
   assign ALU_src2        = src2_q;
   assign Store_Value_sel = store_q;
   assign exe_valid       = e_q.v;

endmodule
